// File: rtl/nand_gate_bist.sv
// Exhaustive self-test of a WIDTH-input gate built only from 2-input NANDs, checked against a behavioural reference.
// Define FAULT_INJECT_EN to add inj_en/inj_mask, which corrupt gate_out so the checker's detection can be exercised.
module nand_gate_bist #(
   parameter int WIDTH = 2,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mode,
`ifdef FAULT_INJECT_EN
   input  logic             inj_en,
   input  logic [WIDTH-1:0] inj_mask,
`endif
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] vec,
   output logic             gate_out,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] first_fail
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] VEC_LAST = '1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t             state_reg, state_next;
   logic [2:0]         mode_reg, mode_next;
   logic [WIDTH-1:0]   vec_reg, vec_next;
   logic [ERR_W-1:0]   err_reg, err_next;
   logic [WIDTH-1:0]   first_fail_reg, first_fail_next;
   logic               seen_reg, seen_next;

   logic               gut;
   logic               ref_bit;
   logic               mismatch;

   function automatic logic nand2(input logic a, input logic b);
      return ~(a & b);
   endfunction

   // Reduction chains: element gi holds the function of vec[gi:0]
   logic and_c [WIDTH];
   logic or_c  [WIDTH];
   logic xor_c [WIDTH];
   logic inv_v [WIDTH];

   assign and_c[0] = vec_reg[0];
   assign or_c[0]  = vec_reg[0];
   assign xor_c[0] = vec_reg[0];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
         assign inv_v[gi] = nand2(vec_reg[gi], vec_reg[gi]);
      end
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
         logic and_n;
         logic xor_n;
         assign and_n     = nand2(and_c[gi-1], vec_reg[gi]);
         assign and_c[gi] = nand2(and_n, and_n);
         // a | b == nand(~a, ~b)
         assign or_c[gi]  = nand2(nand2(or_c[gi-1], or_c[gi-1]), inv_v[gi]);
         assign xor_n     = nand2(xor_c[gi-1], vec_reg[gi]);
         assign xor_c[gi] = nand2(nand2(xor_c[gi-1], xor_n), nand2(vec_reg[gi], xor_n));
      end
   endgenerate

   always_comb begin
      gut = 1'b0;
      case (mode_reg)
         3'd0:    gut = inv_v[0];
         3'd1:    gut = and_c[WIDTH-1];
         3'd2:    gut = or_c[WIDTH-1];
         3'd3:    gut = nand2(and_c[WIDTH-1], and_c[WIDTH-1]);
         3'd4:    gut = nand2(or_c[WIDTH-1], or_c[WIDTH-1]);
         3'd5:    gut = xor_c[WIDTH-1];
         3'd6:    gut = nand2(xor_c[WIDTH-1], xor_c[WIDTH-1]);
         default: gut = 1'b0;
      endcase
   end

   always_comb begin
      ref_bit = 1'b0;
      case (mode_reg)
         3'd0:    ref_bit = ~vec_reg[0];
         3'd1:    ref_bit = &vec_reg;
         3'd2:    ref_bit = |vec_reg;
         3'd3:    ref_bit = ~&vec_reg;
         3'd4:    ref_bit = ~|vec_reg;
         3'd5:    ref_bit = ^vec_reg;
         3'd6:    ref_bit = ~^vec_reg;
         default: ref_bit = 1'b0;
      endcase
   end

`ifdef FAULT_INJECT_EN
   assign gate_out = gut ^ (inj_en && ((vec_reg & inj_mask) == inj_mask));
`else
   assign gate_out = gut;
`endif

   assign mismatch = (gate_out != ref_bit);

   always_comb begin
      state_next      = state_reg;
      mode_next       = mode_reg;
      vec_next        = vec_reg;
      err_next        = err_reg;
      first_fail_next = first_fail_reg;
      seen_next       = seen_reg;
      case (state_reg)
         RUN: begin
            if (mismatch) begin
               if (err_reg != ERR_MAX) err_next = err_reg + 1'b1;
               if (!seen_reg) begin
                  seen_next       = 1'b1;
                  first_fail_next = vec_reg;
               end
            end
            if (vec_reg == VEC_LAST) state_next = DONE;
            else                     vec_next   = vec_reg + 1'b1;
         end
         default: begin
            // IDLE and DONE share acceptance; mode 7 is reserved and never starts a sweep
            if (start && (mode != 3'd7)) begin
               state_next      = RUN;
               mode_next       = mode;
               vec_next        = '0;
               err_next        = '0;
               first_fail_next = '0;
               seen_next       = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         mode_reg       <= '0;
         vec_reg        <= '0;
         err_reg        <= '0;
         first_fail_reg <= '0;
         seen_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mode_reg       <= mode_next;
         vec_reg        <= vec_next;
         err_reg        <= err_next;
         first_fail_reg <= first_fail_next;
         seen_reg       <= seen_next;
      end
   end

   assign busy       = (state_reg == RUN);
   assign done       = (state_reg == DONE);
   assign pass       = done && (err_reg == '0);
   assign vec        = vec_reg;
   assign err_count  = err_reg;
   assign first_fail = first_fail_reg;

endmodule
